// File: rtl/ws2812_rx_decoder.sv
// WS2812 serial receiver: decodes high-pulse widths into 24-bit pixels and frame summaries.
// Pin to edge detection is 3 cycles; no backpressure, so strobes must be consumed when they fire.
module ws2812_rx_decoder #(
  parameter int NUM_LEDS   = 16,
  parameter int T_HIGH_MIN = 20,
  parameter int T_THRESH   = 75,
  parameter int T_HIGH_MAX = 140,
  parameter int T_RESET    = 6250
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ws2812_din,
  output logic [23:0]                     pix_data,
  output logic [$clog2(NUM_LEDS)-1:0]     pix_idx,
  output logic                            pix_valid,
  output logic                            frame_done,
  output logic [$clog2(NUM_LEDS+1)-1:0]   frame_len,
  output logic                            frame_err,
  output logic                            busy
);

  localparam int IW = $clog2(NUM_LEDS);
  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int HW = $clog2(T_HIGH_MAX + 2);
  localparam int LW = $clog2(T_RESET + 1);

  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_MIN = HW'(T_HIGH_MIN);
  localparam logic [HW-1:0] H_THR = HW'(T_THRESH);
  localparam logic [HW-1:0] H_SAT = HW'(T_HIGH_MAX + 1);
  localparam logic [LW-1:0] L_ONE = LW'(1);
  localparam logic [LW-1:0] L_RST = LW'(T_RESET);
  localparam logic [PW-1:0] P_MAX = PW'(NUM_LEDS);

  typedef enum logic [1:0] {S_WAIT_RST, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t state_q, state_d;

  logic din_s1_q, din_s2_q, din_s3_q;
  logic rise, fall;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [22:0]   sh_q, sh_d;
  logic          ovf_q, ovf_d;

  logic [23:0]   pix_data_q, pix_data_d;
  logic [IW-1:0] pix_idx_q, pix_idx_d;
  logic          pix_valid_q, pix_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [PW-1:0] frame_len_q, frame_len_d;
  logic          frame_err_q, frame_err_d;

  logic bit_ev, err_ev, end_ev, bit_val, pix_done;

  // din_s2_q is the synchronised line; din_s3_q is its one-cycle-old copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1_q <= 1'b0;
      din_s2_q <= 1'b0;
      din_s3_q <= 1'b0;
    end else begin
      din_s1_q <= ws2812_din;
      din_s2_q <= din_s1_q;
      din_s3_q <= din_s2_q;
    end
  end

  assign rise     = din_s2_q & ~din_s3_q;
  assign fall     = ~din_s2_q & din_s3_q;
  assign bit_val  = (hcnt_q >= H_THR);
  assign pix_done = bit_ev && (bitcnt_q == 5'd23);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bit_ev  = 1'b0;
    err_ev  = 1'b0;
    end_ev  = 1'b0;
    case (state_q)
      S_WAIT_RST: if (lcnt_q == L_RST && !din_s2_q) state_d = S_IDLE;
      S_IDLE:     if (rise) state_d = S_HIGH;
      S_HIGH: begin
        if (din_s2_q) begin
          if (hcnt_q == H_SAT - H_ONE) begin
            err_ev  = 1'b1;
            state_d = S_WAIT_RST;
          end
        end else if (hcnt_q < H_MIN) begin
          err_ev  = 1'b1;
          state_d = S_WAIT_RST;
        end else begin
          bit_ev  = 1'b1;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
        end else if (lcnt_q == L_RST - L_ONE) begin
          end_ev  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_WAIT_RST;
    endcase
  end

  always_comb begin
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    bitcnt_d     = bitcnt_q;
    pcnt_d       = pcnt_q;
    sh_d         = sh_q;
    ovf_d        = ovf_q;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_len_d  = frame_len_q;
    case (state_q)
      S_WAIT_RST: begin
        if (din_s2_q)             lcnt_d = '0;
        else if (lcnt_q != L_RST) lcnt_d = lcnt_q + L_ONE;
      end
      S_IDLE: begin
        if (rise) begin
          hcnt_d   = H_ONE;
          bitcnt_d = '0;
          pcnt_d   = '0;
          ovf_d    = 1'b0;
          sh_d     = '0;
        end
      end
      S_HIGH: begin
        if (din_s2_q) begin
          if (hcnt_q != H_SAT) hcnt_d = hcnt_q + H_ONE;
        end else if (bit_ev) begin
          sh_d     = {sh_q[21:0], bit_val};
          lcnt_d   = L_ONE;
          bitcnt_d = (bitcnt_q == 5'd23) ? 5'd0 : bitcnt_q + 5'd1;
          if (pix_done) begin
            if (pcnt_q < P_MAX) begin
              pix_data_d  = {sh_q, bit_val};
              pix_idx_d   = pcnt_q[IW-1:0];
              pix_valid_d = 1'b1;
              pcnt_d      = pcnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      S_LOW: begin
        if (rise)                 hcnt_d = H_ONE;
        else if (lcnt_q != L_RST) lcnt_d = lcnt_q + L_ONE;
      end
      default: ;
    endcase
    // WAIT_RST must see a full reset period of low starting from the error itself
    if (err_ev) begin
      frame_err_d = 1'b1;
      frame_len_d = pcnt_q;
      lcnt_d      = '0;
    end
    if (end_ev) begin
      frame_len_d = pcnt_q;
      if (bitcnt_q == 5'd0 && !ovf_q) frame_done_d = 1'b1;
      else                            frame_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      bitcnt_q     <= '0;
      pcnt_q       <= '0;
      sh_q         <= '0;
      ovf_q        <= 1'b0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      bitcnt_q     <= bitcnt_d;
      pcnt_q       <= pcnt_d;
      sh_q         <= sh_d;
      ovf_q        <= ovf_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == S_HIGH) || (state_q == S_LOW);

endmodule
